// File: rtl/pulse_stretch.sv
// Stretches each request pulse into a HOLD_CYCLES high burst plus GAP_CYCLES low; level_out rises 1 cycle after sampling.
// No backpressure: requests arriving mid-burst queue in a saturating counter, excess requests are dropped and flagged sticky.
module pulse_stretch #(
    parameter int HOLD_CYCLES = 5000000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int CNT_W       = 26,
    parameter int PEND_W      = 3
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              pulse_in,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             deq;
    logic             enq;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        deq       = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // A live pulse wins over the backlog; either way pending nets the same.
                if (pulse_in) begin
                    state_nxt = HIGH;
                    cnt_nxt   = HOLD_LOAD;
                end else if (pending != '0) begin
                    state_nxt = HIGH;
                    cnt_nxt   = HOLD_LOAD;
                    deq       = 1'b1;
                end
            end
            HIGH: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (pending != '0) begin
                    state_nxt = HIGH;
                    cnt_nxt   = HOLD_LOAD;
                    deq       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pulses in IDLE are consumed directly, so only busy states queue them.
    assign enq = pulse_in && (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= (state_nxt == HIGH);
            busy      <= (state_nxt != IDLE);
            if (enq && !deq) begin
                if (pending == PEND_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + PEND_W'(1);
                end
            end else if (deq && !enq) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed scenarios for pulse_stretch; a monitor measures burst/gap lengths against a queue of expected bursts.
module tb_pulse_stretch;

    localparam int HOLD = 4;
    localparam int GAPC = 3;
    localparam int PW   = 2;

    logic          clk_in = 1'b0;
    logic          reset = 1'b1;
    logic          pulse_in = 1'b0;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int gap;   // expected low cycles before this burst, -1 = first burst of a scenario
        int hold;  // expected high cycles
    } burst_t;

    burst_t exp_q[$];

    pulse_stretch #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAPC),
        .CNT_W      (4),
        .PEND_W     (PW)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .pulse_in (pulse_in),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples just after each posedge, pops an expected burst on every rising level_out.
    logic   prev_lvl = 1'b0;
    int     high_run = 0;
    int     low_run  = 0;
    logic   have_cur = 1'b0;
    burst_t cur;

    always begin
        @(posedge clk_in);
        #1;
        if (level_out === 1'b1 && !prev_lvl) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_burst", 1, 0);
                have_cur = 1'b0;
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                if (cur.gap >= 0) chk("gap_len", low_run, cur.gap);
            end
            high_run = 1;
        end else if (level_out === 1'b1) begin
            high_run++;
        end else if (prev_lvl) begin
            if (have_cur) chk("hold_len", high_run, cur.hold);
            have_cur = 1'b0;
            low_run  = 1;
        end else begin
            low_run++;
        end
        prev_lvl = (level_out === 1'b1);
    end

    task automatic apply_reset();
        reset    = 1'b1;
        pulse_in = 1'b0;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        chk("rst_level", level_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
    endtask

    // Drives edge e with pulse_mask[e]/rst_mask[e]; checks sampled after edge e at the following negedge.
    task automatic run(input int tid, input logic [63:0] pulse_mask, input logic [63:0] rst_mask);
        for (int e = 1; e <= 60; e++) begin
            pulse_in = pulse_mask[e];
            reset    = rst_mask[e];
            @(negedge clk_in);
            case (tid)
                1: begin
                    if (e == 9)  begin chk("t1_lvl_e9", level_out, 0); chk("t1_busy_e9", busy, 0); end
                    if (e == 10) begin chk("t1_lvl_e10", level_out, 1); chk("t1_busy_e10", busy, 1); end
                    if (e == 13) chk("t1_lvl_e13", level_out, 1);
                    if (e == 14) begin chk("t1_lvl_e14", level_out, 0); chk("t1_busy_e14", busy, 1); end
                    if (e == 16) chk("t1_busy_e16", busy, 1);
                    if (e == 17) begin chk("t1_busy_e17", busy, 0); chk("t1_pend_e17", pending, 0); end
                end
                2: begin
                    if (e == 12) chk("t2_pend_e12", pending, 1);
                    if (e == 13) chk("t2_pend_e13", pending, 2);
                end
                3: begin
                    if (e == 13) begin chk("t3_pend_e13", pending, 3); chk("t3_ovf_e13", overflow, 0); end
                    if (e == 14) begin chk("t3_pend_e14", pending, 3); chk("t3_ovf_e14", overflow, 1); end
                    if (e == 15) begin chk("t3_pend_e15", pending, 3); chk("t3_ovf_e15", overflow, 1); end
                    if (e == 30) chk("t3_ovf_e30", overflow, 1);
                end
                4: begin
                    if (e == 11) chk("t4_pend_e11", pending, 1);
                    if (e == 16) begin chk("t4_lvl_e16", level_out, 0); chk("t4_busy_e16", busy, 1); end
                    if (e == 17) begin
                        chk("t4_lvl_e17", level_out, 1);
                        chk("t4_pend_e17", pending, 1);
                        chk("t4_ovf_e17", overflow, 0);
                    end
                end
                5: begin
                    if (e == 17) begin
                        chk("t5_busy_e17", busy, 0);
                        chk("t5_lvl_e17", level_out, 0);
                        chk("t5_pend_e17", pending, 1);
                    end
                    if (e == 18) begin chk("t5_lvl_e18", level_out, 1); chk("t5_pend_e18", pending, 0); end
                end
                6: begin
                    if (e == 12) chk("t6_pend_e12", pending, 2);
                    if (e == 13) begin
                        chk("t6_lvl_e13", level_out, 0);
                        chk("t6_busy_e13", busy, 0);
                        chk("t6_pend_e13", pending, 0);
                        chk("t6_ovf_e13", overflow, 0);
                    end
                end
                default: ;
            endcase
        end
        pulse_in = 1'b0;
        reset    = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_level", level_out, 0);
        chk("end_pending", pending, 0);
        chk("bursts_missing", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] pm;
        logic [63:0] rm;

        // 1: single pulse
        apply_reset();
        exp_q.push_back('{gap: -1, hold: HOLD});
        pm = '0; pm[10] = 1'b1; rm = '0;
        run(1, pm, rm);
        chk("t1_ovf_end", overflow, 0);

        // 2: three queued bursts
        apply_reset();
        exp_q.push_back('{gap: -1, hold: HOLD});
        exp_q.push_back('{gap: GAPC, hold: HOLD});
        exp_q.push_back('{gap: GAPC, hold: HOLD});
        pm = '0; pm[10] = 1'b1; pm[12] = 1'b1; pm[13] = 1'b1;
        run(2, pm, rm);
        chk("t2_ovf_end", overflow, 0);

        // 3: saturation and sticky overflow
        apply_reset();
        exp_q.push_back('{gap: -1, hold: HOLD});
        for (int i = 0; i < 3; i++) exp_q.push_back('{gap: GAPC, hold: HOLD});
        pm = '0;
        for (int i = 10; i <= 15; i++) pm[i] = 1'b1;
        run(3, pm, rm);
        chk("t3_ovf_end", overflow, 1);

        // 4: pulse on final gap edge with one pending
        apply_reset();
        exp_q.push_back('{gap: -1, hold: HOLD});
        exp_q.push_back('{gap: GAPC, hold: HOLD});
        exp_q.push_back('{gap: GAPC, hold: HOLD});
        pm = '0; pm[10] = 1'b1; pm[11] = 1'b1; pm[17] = 1'b1;
        run(4, pm, rm);
        chk("t4_ovf_end", overflow, 0);

        // 5: pulse on final gap edge with nothing pending
        apply_reset();
        exp_q.push_back('{gap: -1, hold: HOLD});
        exp_q.push_back('{gap: GAPC + 1, hold: HOLD});
        pm = '0; pm[10] = 1'b1; pm[17] = 1'b1;
        run(5, pm, rm);

        // 6: reset mid-burst with backlog and a coincident pulse
        apply_reset();
        exp_q.push_back('{gap: -1, hold: 3});
        pm = '0; pm[10] = 1'b1; pm[11] = 1'b1; pm[12] = 1'b1; pm[13] = 1'b1;
        rm = '0; rm[13] = 1'b1;
        run(6, pm, rm);
        chk("t6_ovf_end", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
